taxel_scan_controller: RTL and testbench
========================================

Name: taxel_scan_controller

Overview:
Sequences a multiplexed ROWS x COLS tactile taxel array through one shared 12-bit ADC. For each taxel it selects the row and column, waits a settle time, runs an ADC conversion handshake, and classifies the sample against the user lower/upper threshold bounds. It builds a per-frame in-range bitmap. It sits between the threshold-entry logic, which supplies the bounds, and the downstream mask/display consumers.

Parameters:
ROWS, 4, number of row selects
COLS, 4, number of column selects
SETTLE_CYCLES, 16, clock cycles between select change and ADC start (>=1)
ADC_TIMEOUT, 64, maximum CONVERT cycles waiting for adc_valid_in (>=2)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  level; begin a frame when idle
continuous_in  in  1  level; rescan back-to-back while high
clear_err_in  in  1  clears sticky error_out
lower_bound_in  in  12  inclusive lower threshold
upper_bound_in  in  12  inclusive upper threshold
row_sel_out  out  $clog2(ROWS)  current row
col_sel_out  out  $clog2(COLS)  current column
adc_start_out  out  1  one-cycle conversion request
adc_valid_in  in  1  conversion result valid
adc_data_in  in  12  conversion result
pixel_valid_out  out  1  one-cycle pulse per classified taxel
pixel_idx_out  out  $clog2(ROWS*COLS)  row*COLS+col of that taxel
pixel_data_out  out  12  captured sample
pixel_in_range_out  out  1  classification of that taxel
mask_out  out  ROWS*COLS  last completed frame bitmap, bit idx = taxel idx
frame_done_out  out  1  one-cycle pulse when mask_out updates
busy_out  out  1  high in any state other than IDLE
error_out  out  1  sticky ADC-timeout flag

Behaviour:
- Clock is clk_in. Reset is asynchronous, active-low on rst_n_in. All outputs and state clear immediately: IDLE, selects 0, mask_out 0, all pulses 0, error_out 0.
- States: IDLE, SETTLE, CONVERT, DONE. All outputs are registered.
- IDLE -> SETTLE when start_in or continuous_in is high. On that edge the block latches lower_bound_in and upper_bound_in, and sets idx to 0 and the shadow mask to 0. Bound changes mid-frame have no effect until the next frame.
- SETTLE: counts SETTLE_CYCLES cycles, then enters CONVERT.
- CONVERT: adc_start_out is high for exactly the first CONVERT cycle. adc_valid_in is ignored in that cycle and sampled from the second cycle onward. adc_valid_in is ignored in every other state.
- Latency: the first adc_start_out occurs SETTLE_CYCLES+1 cycles after start_in is sampled high.
- On accepted valid: the block captures adc_data_in.
  - in_range = (lower <= data) && (data <= upper), unsigned. If lower > upper, in_range is always 0.
  - Next cycle: pixel_valid_out pulses with idx, data and in_range, and the shadow bit [idx] is written.
- Timeout: if ADC_TIMEOUT CONVERT cycles elapse with no valid, error_out is set to 1. The shadow bit stays 0 and pixel_valid_out is not pulsed for that taxel. The scan continues.
- After each taxel: col increments; on wrap to 0, row increments. If the taxel was the last one (idx = ROWS*COLS-1), go to DONE; otherwise go to SETTLE.
- DONE, one cycle: mask_out <= shadow, completed bit included. frame_done_out pulses. mask_out never shows a partial frame.
- From DONE: if continuous_in is high, go to SETTLE with a new bound latch and idx 0. Otherwise go to IDLE. A start_in already high in DONE does not restart the scan without continuous_in.
- error_out clears on clear_err_in only in a cycle with no new timeout. A simultaneous timeout wins.
- Dropping continuous_in mid-frame finishes the current frame, then returns to IDLE.

Decomposition:
- Shared package taxel_scan_pkg:
  - state enum scan_state_t {IDLE, SETTLE, CONVERT, DONE}
  - DATA_WIDTH=12 constant
  - function for the index width
- One natural sub-module: scan_index_counter. It is sequential, holds row/col with nested wrap, and takes an inc/clear input and a last_out flag.
- The settle and timeout waits share one cycle counter in the top level.

Test Plan:
All scenarios use ROWS=2, COLS=2, SETTLE_CYCLES=4, ADC_TIMEOUT=8, and a bench ADC model answering 3 cycles after adc_start_out.
1. Reset mid-CONVERT with rst_n_in low -> in the same cycle, adc_start_out=0, busy_out=0, mask_out=0, error_out=0; after release the block is in IDLE.
2. Bounds 0x100/0x800; ADC returns 0x050, 0x100, 0x800, 0x801 -> pixel_in_range 0,1,1,0; mask_out=4'b0110 only at the frame_done_out pulse; first adc_start_out 5 cycles after start_in.
3. Bounds 0x900/0x100; any samples -> every pixel_in_range_out=0 and mask_out=0.
4. ADC withholds valid for idx 2 with all samples in range -> error_out rises after 8 CONVERT cycles; no pixel_valid_out for idx 2; mask_out=4'b1011; clear_err_in then drops error_out.
5. continuous_in held, upper bound changed from 0x800 to 0x080 during frame 1 -> frame 1 uses 0x800; frame 2 uses 0x080; DONE goes directly to SETTLE with no IDLE cycle.
6. adc_valid_in pulsed during SETTLE and during the adc_start_out cycle -> ignored; no pixel_valid_out and no state change.

Source files
------------

// File: rtl/taxel_scan_pkg.sv
// Shared types and helpers for the taxel scan controller.
package taxel_scan_pkg;

  localparam int DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    DONE
  } scan_state_t;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_index_counter.sv
// Row/column walker for the taxel matrix: column is the fast index and
// wraps into the row. last_out flags the final taxel of a frame.
module scan_index_counter
  import taxel_scan_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       clear_in,
  input  logic                       inc_in,
  output logic [idx_width(ROWS)-1:0] row_out,
  output logic [idx_width(COLS)-1:0] col_out,
  output logic                       last_out
);

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  // Nested wrap: column advances every taxel, row advances on column wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      row_out <= '0;
      col_out <= '0;
    end else if (clear_in) begin
      row_out <= '0;
      col_out <= '0;
    end else if (inc_in) begin
      if (col_out == COL_LAST) begin
        col_out <= '0;
        if (row_out == ROW_LAST) begin
          row_out <= '0;
        end else begin
          row_out <= row_out + ROW_W'(1);
        end
      end else begin
        col_out <= col_out + COL_W'(1);
      end
    end
  end

  assign last_out = (row_out == ROW_LAST) && (col_out == COL_LAST);

endmodule

// File: rtl/taxel_scan_controller.sv
// Walks a ROWS x COLS taxel matrix through one shared ADC, classifies each
// sample against bounds latched at frame start and publishes a frame mask.
//
// state   | meaning
// IDLE    | waiting for start_in or continuous_in
// SETTLE  | selects applied, letting the analog path settle
// CONVERT | ADC requested, waiting for adc_valid_in or timeout
// DONE    | publish mask_out / frame_done_out, then rescan or go idle
module taxel_scan_controller
  import taxel_scan_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int ADC_TIMEOUT   = 64
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic                            continuous_in,
  input  logic                            clear_err_in,
  input  logic [DATA_WIDTH-1:0]           lower_bound_in,
  input  logic [DATA_WIDTH-1:0]           upper_bound_in,
  output logic [idx_width(ROWS)-1:0]      row_sel_out,
  output logic [idx_width(COLS)-1:0]      col_sel_out,
  output logic                            adc_start_out,
  input  logic                            adc_valid_in,
  input  logic [DATA_WIDTH-1:0]           adc_data_in,
  output logic                            pixel_valid_out,
  output logic [idx_width(ROWS*COLS)-1:0] pixel_idx_out,
  output logic [DATA_WIDTH-1:0]           pixel_data_out,
  output logic                            pixel_in_range_out,
  output logic [ROWS*COLS-1:0]            mask_out,
  output logic                            frame_done_out,
  output logic                            busy_out,
  output logic                            error_out
);

  localparam int NUM_TAXELS = ROWS * COLS;
  localparam int IDX_W      = idx_width(NUM_TAXELS);
  // One counter serves both the settle wait and the conversion timeout.
  localparam int CNT_MAX    = (SETTLE_CYCLES > ADC_TIMEOUT - 1) ? SETTLE_CYCLES : ADC_TIMEOUT - 1;
  localparam int CNT_W      = idx_width(CNT_MAX + 1);
  // Settle counts down SETTLE_CYCLES..0, so the first adc_start_out lands
  // SETTLE_CYCLES+1 cycles after the select change / frame start.
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(ADC_TIMEOUT - 1);

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] lower_q;
  logic [DATA_WIDTH-1:0] upper_q;
  logic [NUM_TAXELS-1:0] shadow;
  logic [IDX_W-1:0]      cur_idx;
  logic                  last_taxel;
  logic                  frame_start;
  logic                  sample_accept;
  logic                  sample_timeout;
  logic                  taxel_end;
  logic                  in_range;

  scan_index_counter #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_index (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (frame_start),
    .inc_in   (taxel_end),
    .row_out  (row_sel_out),
    .col_out  (col_sel_out),
    .last_out (last_taxel)
  );

  assign cur_idx = IDX_W'(row_sel_out) * IDX_W'(COLS) + IDX_W'(col_sel_out);

  // An inverted window (lower > upper) can never satisfy both compares.
  assign in_range = (adc_data_in >= lower_q) && (adc_data_in <= upper_q);

  assign taxel_end = sample_accept || sample_timeout;

  // Per-state decode of frame start and conversion outcome.
  always_comb begin
    frame_start    = 1'b0;
    sample_accept  = 1'b0;
    sample_timeout = 1'b0;
    case (state)
      IDLE:    frame_start = start_in || continuous_in;
      CONVERT: begin
        // adc_start_out is high only in the first CONVERT cycle; a valid
        // there is too early to belong to this request.
        sample_accept  = !adc_start_out && adc_valid_in;
        sample_timeout = !sample_accept && (cnt == '0);
      end
      DONE:    frame_start = continuous_in;
      default: ;
    endcase
  end

  // Scan sequencer with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      cnt                <= '0;
      lower_q            <= '0;
      upper_q            <= '0;
      shadow             <= '0;
      mask_out           <= '0;
      adc_start_out      <= 1'b0;
      pixel_valid_out    <= 1'b0;
      pixel_idx_out      <= '0;
      pixel_data_out     <= '0;
      pixel_in_range_out <= 1'b0;
      frame_done_out     <= 1'b0;
      busy_out           <= 1'b0;
      error_out          <= 1'b0;
    end else begin
      adc_start_out   <= 1'b0;
      pixel_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      // A timeout in the same cycle overrides this below.
      if (clear_err_in) begin
        error_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= SETTLE;
            busy_out <= 1'b1;
            cnt      <= SETTLE_LOAD;
            lower_q  <= lower_bound_in;
            upper_q  <= upper_bound_in;
            shadow   <= '0;
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state         <= CONVERT;
            adc_start_out <= 1'b1;
            cnt           <= TIMEOUT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        CONVERT: begin
          if (sample_accept) begin
            pixel_valid_out    <= 1'b1;
            pixel_idx_out      <= cur_idx;
            pixel_data_out     <= adc_data_in;
            pixel_in_range_out <= in_range;
            shadow[cur_idx]    <= in_range;
          end
          if (sample_timeout) begin
            error_out <= 1'b1;
          end
          if (taxel_end) begin
            if (last_taxel) begin
              state <= DONE;
            end else begin
              state <= SETTLE;
              cnt   <= SETTLE_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          mask_out       <= shadow;
          frame_done_out <= 1'b1;
          if (frame_start) begin
            state   <= SETTLE;
            cnt     <= SETTLE_LOAD;
            lower_q <= lower_bound_in;
            upper_q <= upper_bound_in;
            shadow  <= '0;
          end else begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taxel_scan_controller.sv
// Directed + randomized bench for taxel_scan_controller on a 2x2 array.
module tb_taxel_scan_controller;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int SETTLE = 4;
  localparam int TMO    = 8;
  localparam int NT     = ROWS * COLS;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        continuous_in = 1'b0;
  logic        clear_err_in = 1'b0;
  logic [11:0] lower_bound_in = '0;
  logic [11:0] upper_bound_in = '0;
  logic [0:0]  row_sel_out;
  logic [0:0]  col_sel_out;
  logic        adc_start_out;
  logic        adc_valid_in = 1'b0;
  logic [11:0] adc_data_in = '0;
  logic        pixel_valid_out;
  logic [1:0]  pixel_idx_out;
  logic [11:0] pixel_data_out;
  logic        pixel_in_range_out;
  logic [3:0]  mask_out;
  logic        frame_done_out;
  logic        busy_out;
  logic        error_out;

  taxel_scan_controller #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .continuous_in(continuous_in), .clear_err_in(clear_err_in),
    .lower_bound_in(lower_bound_in), .upper_bound_in(upper_bound_in),
    .row_sel_out(row_sel_out), .col_sel_out(col_sel_out),
    .adc_start_out(adc_start_out), .adc_valid_in(adc_valid_in),
    .adc_data_in(adc_data_in), .pixel_valid_out(pixel_valid_out),
    .pixel_idx_out(pixel_idx_out), .pixel_data_out(pixel_data_out),
    .pixel_in_range_out(pixel_in_range_out), .mask_out(mask_out),
    .frame_done_out(frame_done_out), .busy_out(busy_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ADC model state and stimulus knobs
  logic [11:0] data_tab[4];
  bit          withhold[4];
  bit          glitch_en = 1'b0;
  bit          force_valid = 1'b0;
  int          pend = 0;
  int          pend_idx = 0;
  int          start_cyc[4];

  // Observations
  int          pq_idx[$];
  int          pq_data[$];
  int          pq_ir[$];
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  logic        fd_busy = 1'b0;
  logic [3:0]  fd_mask = '0;
  logic [3:0]  mask_prev = '0;
  logic        err_prev = 1'b0;
  int          err_rise_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  always @(posedge clk_in) cyc++;

  // ADC: answers 3 cycles after each request with data_tab[taxel]
  always @(posedge clk_in) begin
    #2;
    adc_valid_in = 1'b0;
    adc_data_in  = 12'($urandom_range(0, 4095));
    if (adc_start_out === 1'b1) begin
      pend_idx = int'(row_sel_out) * COLS + int'(col_sel_out);
      pend = 3;
      start_cyc[pend_idx] = cyc;
      if (glitch_en) adc_valid_in = 1'b1;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0 && !withhold[pend_idx]) begin
        adc_valid_in = 1'b1;
        adc_data_in  = data_tab[pend_idx];
      end
    end
    if (force_valid) adc_valid_in = 1'b1;
  end

  // Output monitor on the falling edge
  always @(negedge clk_in) begin
    if (pixel_valid_out === 1'b1) begin
      pq_idx.push_back(int'(pixel_idx_out));
      pq_data.push_back(int'(pixel_data_out));
      pq_ir.push_back(int'(pixel_in_range_out));
    end
    if (error_out === 1'b1 && err_prev !== 1'b1) err_rise_cyc = cyc;
    err_prev = error_out;
    if (frame_done_out === 1'b1) begin
      fd_cnt++;
      fd_cyc  = cyc;
      fd_busy = busy_out;
      fd_mask = mask_out;
    end else if (rst_n_in === 1'b1) begin
      check("mask_hold", 32'(mask_out), 32'(mask_prev));
    end
    mask_prev = mask_out;
  end

  task automatic wait_frame(input string tag);
    int n;
    int f0;
    n = 0;
    f0 = fd_cnt;
    while (fd_cnt == f0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_frame_timeout"}, 32'(fd_cnt != f0), 32'd1);
  endtask

  task automatic start_frame(output int k);
    k = cyc;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  // Reference: every answered taxel in index order, in range iff lo<=d<=hi.
  task automatic check_frame(input string tag, input logic [11:0] lo, input logic [11:0] hi);
    logic [3:0] em;
    int k;
    bit ir;
    em = '0;
    k = 0;
    for (int i = 0; i < NT; i++) begin
      if (!withhold[i]) begin
        ir = (lo <= hi) && (data_tab[i] >= lo) && (data_tab[i] <= hi);
        em[i] = ir;
        if (k < pq_idx.size()) begin
          check({tag, "_idx"}, 32'(pq_idx[k]), 32'(i));
          check({tag, "_data"}, 32'(pq_data[k]), 32'(data_tab[i]));
          check({tag, "_inrange"}, 32'(pq_ir[k]), 32'(ir));
        end
        k++;
      end
    end
    check({tag, "_count"}, 32'(pq_idx.size()), 32'(k));
    check({tag, "_mask"}, 32'(fd_mask), 32'(em));
    pq_idx.delete();
    pq_data.delete();
    pq_ir.delete();
  endtask

  task automatic fill_boundary(input logic [11:0] lo, input logic [11:0] hi);
    for (int i = 0; i < NT; i++) begin
      case ($urandom_range(0, 4))
        0: data_tab[i] = lo;
        1: data_tab[i] = hi;
        2: data_tab[i] = lo - 12'd1;
        3: data_tab[i] = hi + 12'd1;
        default: data_tab[i] = 12'($urandom_range(0, 4095));
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int cnt_busy;
    int cnt_pix;
    int f1;
    logic [11:0] lo;
    logic [11:0] hi;

    withhold = '{default: 1'b0};
    data_tab = '{default: 12'h000};
    start_cyc = '{default: 0};

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_adc_start", 32'(adc_start_out), 32'd0);
    check("rst_mask", 32'(mask_out), 32'd0);
    check("rst_error", 32'(error_out), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid_out), 32'd0);
    check("rst_frame_done", 32'(frame_done_out), 32'd0);
    check("rst_sel", 32'({row_sel_out, col_sel_out}), 32'd0);
    rst_n_in = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy_out), 32'd0);

    // Directed bounds 0x100..0x800 with edge samples
    lower_bound_in = 12'h100;
    upper_bound_in = 12'h800;
    data_tab = '{12'h050, 12'h100, 12'h800, 12'h801};
    start_frame(k);
    wait_frame("t2");
    check("t2_latency", 32'(start_cyc[0] - (k + 1)), 32'(SETTLE + 1));
    check("t2_mask_value", 32'(fd_mask), 32'b0110);
    check_frame("t2", 12'h100, 12'h800);

    // Inverted window
    lower_bound_in = 12'h900;
    upper_bound_in = 12'h100;
    fill_boundary(12'h900, 12'h100);
    start_frame(k);
    wait_frame("t3");
    check_frame("t3", 12'h900, 12'h100);

    // Random windows with samples clustered at the bounds
    for (int r = 0; r < 4; r++) begin
      lo = 12'($urandom_range(0, 2047));
      hi = 12'($urandom_range(int'(lo), 4095));
      lower_bound_in = lo;
      upper_bound_in = hi;
      fill_boundary(lo, hi);
      start_frame(k);
      wait_frame("rnd");
      check_frame("rnd", lo, hi);
    end

    // Timeout on taxel 2
    lower_bound_in = 12'h000;
    upper_bound_in = 12'hFFF;
    for (int i = 0; i < NT; i++) data_tab[i] = 12'($urandom_range(0, 4095));
    withhold[2] = 1'b1;
    start_frame(k);
    wait_frame("t4");
    check("t4_err_delay", 32'(err_rise_cyc - start_cyc[2]), 32'(TMO));
    check("t4_error", 32'(error_out), 32'd1);
    check("t4_mask_value", 32'(fd_mask), 32'b1011);
    check_frame("t4", 12'h000, 12'hFFF);
    clear_err_in = 1'b1;
    tick();
    clear_err_in = 1'b0;
    check("t4_err_clear", 32'(error_out), 32'd0);

    // Timeout with clear_err_in held, then reset during a request cycle
    withhold = '{default: 1'b0};
    withhold[0] = 1'b1;
    clear_err_in = 1'b1;
    start_frame(k);
    n = 0;
    while (!(adc_start_out === 1'b1 && col_sel_out == 1'b1 && row_sel_out == 1'b0) && n < 200) begin
      tick();
      n++;
    end
    check("t1_reach", 32'(n < 200), 32'd1);
    check("t1_timeout_wins", 32'(err_rise_cyc - start_cyc[0]), 32'(TMO));
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t1_adc_start", 32'(adc_start_out), 32'd0);
    check("t1_busy", 32'(busy_out), 32'd0);
    check("t1_mask", 32'(mask_out), 32'd0);
    check("t1_error", 32'(error_out), 32'd0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    clear_err_in = 1'b0;
    withhold = '{default: 1'b0};
    pq_idx.delete();
    pq_data.delete();
    pq_ir.delete();
    cnt_busy = 0;
    cnt_pix = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy_out !== 1'b0) cnt_busy++;
      if (pixel_valid_out !== 1'b0) cnt_pix++;
    end
    check("t1_idle_busy", 32'(cnt_busy), 32'd0);
    check("t1_idle_pixels", 32'(cnt_pix), 32'd0);
    check("t1_idle_sel", 32'({row_sel_out, col_sel_out}), 32'd0);

    // Continuous scan with a mid-frame bound change
    lower_bound_in = 12'h000;
    upper_bound_in = 12'h800;
    for (int i = 0; i < NT; i++) data_tab[i] = 12'($urandom_range(0, 4095));
    data_tab[0] = 12'h400;
    data_tab[1] = 12'h050;
    continuous_in = 1'b1;
    n = 0;
    while (pq_idx.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    check("t5_first_pixel", 32'(n < 200), 32'd1);
    upper_bound_in = 12'h080;
    wait_frame("t5_f1");
    check("t5_f1_busy", 32'(fd_busy), 32'd1);
    check_frame("t5_f1", 12'h000, 12'h800);
    continuous_in = 1'b0;
    f1 = fd_cyc;
    repeat (8) tick();
    check("t5_no_idle_gap", 32'(start_cyc[0] - f1), 32'(SETTLE + 1));
    wait_frame("t5_f2");
    check("t5_f2_busy", 32'(fd_busy), 32'd0);
    check_frame("t5_f2", 12'h000, 12'h080);

    // Early valids: during SETTLE and in every request cycle
    lo = 12'($urandom_range(0, 2047));
    hi = 12'($urandom_range(int'(lo), 4095));
    lower_bound_in = lo;
    upper_bound_in = hi;
    fill_boundary(lo, hi);
    glitch_en = 1'b1;
    k = cyc;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    check("t6_settle_no_pixel", 32'(pixel_valid_out), 32'd0);
    check("t6_settle_busy", 32'(busy_out), 32'd1);
    wait_frame("t6");
    glitch_en = 1'b0;
    check("t6_latency", 32'(start_cyc[0] - (k + 1)), 32'(SETTLE + 1));
    check_frame("t6", lo, hi);
    repeat (3) tick();
    check("t6_idle", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
